relu_maxpool2: RTL
==================

Name: relu_maxpool2

Overview:
- Downstream stage of the 3x3 convolution layer. Consumes its 32-bit signed feature-map stream (valid-qualified, raster order: column index fastest) and applies ReLU, then 2x2 stride-2 max pooling.
- Rescales the result by an arithmetic right shift and saturates it to 16 bits, so the pooled map can feed the next 16-bit convolution layer directly.
- A default 26x26 input map yields a 13x13 output map.

Parameters:
- IN_W, 32, input sample width (signed two's complement).
- OUT_W, 16, output sample width (signed; value always >= 0).
- MAP_W, 26, input map width in samples; column count per row.
- MAP_H, 26, input map height in rows.
- SHIFT, 12, arithmetic right shift applied after pooling (fixed-point rescale).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- data_in  input  IN_W  signed convolution result.
- rdata_r  input  1  data_in valid this cycle.
- data_out  output  OUT_W  pooled, rescaled, saturated sample.
- wdata_r  output  1  data_out valid; one-cycle pulse per pooled sample.
- frame_done  output  1  one-cycle pulse coincident with the last wdata_r of a frame.

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous, active-low. While reset_n=0: data_out=0, wdata_r=0, frame_done=0, col=0, row=0, holding register=0.
- Line buffer: floor(MAP_W/2) entries of IN_W bits. It is not reset and is never read before being written in the current frame.
- Counters:
  - col runs 0..MAP_W-1; row runs 0..MAP_H-1.
  - Both advance only on cycles with rdata_r=1.
  - col wraps to 0 and row increments at col=MAP_W-1.
  - row wraps to 0 after MAP_H-1, and the next frame starts immediately.
- ReLU: v = (data_in[IN_W-1]) ? 0 : data_in. All compares after this point are unsigned on non-negative values.
- Pooling on accepted samples only:
  - row even, col even: hold <= v.
  - row even, col odd: linebuf[col>>1] <= max(hold, v).
  - row odd, col even: hold <= v.
  - row odd, col odd: m = max(linebuf[col>>1], hold, v). A result is issued.
- Output register:
  - When a result is issued, on the next rising edge: data_out <= min(m >>> SHIFT, 2^(OUT_W-1)-1) and wdata_r <= 1.
  - Otherwise wdata_r <= 0 and data_out holds its last value.
  - Latency is 1 cycle from acceptance of the 4th window sample to wdata_r.
- frame_done <= 1 on the same edge as wdata_r when the issuing sample has row = 2*floor(MAP_H/2)-1 and col = 2*floor(MAP_W/2)-1. Otherwise frame_done <= 0.
- Odd MAP_W: the last column of every row is counted but ignored; hold and linebuf are not modified.
- Odd MAP_H: the last row is counted but ignored.
- Valid gaps: rdata_r=0 cycles freeze all state. Output depends only on the accepted-sample sequence.
- Back-to-back: one result can issue every 2 accepted samples on odd rows. No backpressure; the downstream must accept every wdata_r pulse.
- Reset mid-frame: the partial frame is discarded. The first sample after release is treated as (row 0, col 0). No stale wdata_r is produced.
- Saturation: only the upper clamp is possible, because the ReLU output is >= 0.

Decomposition:
- Shared package cnn_pkg: IN_W/OUT_W defaults; map dimensions for layer 1 (26x26) and the pooled size (13x13); the default SHIFT; a saturating-shift function sat_shift(value, shift).
- One natural sub-module: pool_linebuf. It holds the floor(MAP_W/2)-entry register array, with synchronous write and combinational read indexed by col>>1.
- Counters, ReLU, max compare and the output register stay in the top module.

Test Plan:
- 4x4 map, SHIFT=0, raster inputs 1..16, continuous valid -> 4 pulses with data_out = 6, 8, 14, 16. Each pulse arrives 1 cycle after inputs 6, 8, 14, 16 respectively. frame_done accompanies the last pulse only.
- 4x4 map, all inputs negative (-5) -> 4 outputs, all 0. A single +3 at (row 1, col 1) with the rest negative -> first output 3, others 0.
- SHIFT=12, window max 0x7FFFFFFF -> data_out = 0x7FFF (saturated). Window max 0x00010000 -> data_out = 0x0010.
- 1..16 stream with rdata_r deasserted every other cycle -> same 4 values as the first test. wdata_r appears exactly 1 cycle after each qualifying accept.
- 5x5 map, inputs 1..25 -> outputs 7, 9, 17, 19. Row 4 and column 4 are ignored. frame_done comes with 19. A second frame back-to-back reproduces the same values.
- Default 26x26 frame of random signed data vs. reference model -> exactly 169 wdata_r pulses, all values bit-exact. Assert reset_n low mid-frame (after sample 300) -> outputs go to 0 immediately; a restarted full frame then matches the model.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN layer constants and the saturating rescale used between layers.
package cnn_pkg;
  localparam int IN_W       = 32;
  localparam int OUT_W      = 16;
  localparam int L1_MAP_W   = 26;
  localparam int L1_MAP_H   = 26;
  localparam int POOL_W     = 13;
  localparam int POOL_H     = 13;
  localparam int POOL_SHIFT = 12;

  // value is already non-negative, so a logical shift equals the arithmetic one
  function automatic logic [IN_W-1:0] sat_shift(input logic [IN_W-1:0] value,
                                                input int unsigned     shift,
                                                input int unsigned     out_w);
    logic [IN_W-1:0] s, lim;
    s   = value >> shift;
    lim = (IN_W'(1) << (out_w - 1)) - 1'b1;
    return (s > lim) ? lim : s;
  endfunction
endpackage

// File: rtl/pool_linebuf.sv
// Half-row buffer of horizontal pair maxima from the even row of each window.
module pool_linebuf #(
  parameter  int W     = 32,
  parameter  int DEPTH = 13,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  // no reset: every entry is written on the even row before the odd row reads it
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/relu_maxpool2.sv
// ReLU + 2x2/stride-2 max pool over a raster feature-map stream, rescaled and saturated.
module relu_maxpool2
  import cnn_pkg::*;
#(
  parameter int IN_W  = cnn_pkg::IN_W,
  parameter int OUT_W = cnn_pkg::OUT_W,
  parameter int MAP_W = cnn_pkg::L1_MAP_W,
  parameter int MAP_H = cnn_pkg::L1_MAP_H,
  parameter int SHIFT = cnn_pkg::POOL_SHIFT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IN_W-1:0]  data_in,
  input  logic             rdata_r,
  output logic [OUT_W-1:0] data_out,
  output logic             wdata_r,
  output logic             frame_done
);
  localparam int HALF_W = MAP_W / 2;
  localparam int HALF_H = MAP_H / 2;
  localparam int CW     = $clog2(MAP_W);
  localparam int RW     = $clog2(MAP_H);
  localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [IN_W-1:0] hold, v, lb_rd, pair_max, m;
  logic            last_col, last_row, ign, last_win;
  logic            hold_we, lb_we, issue;

  assign last_col = (col == CW'(MAP_W - 1));
  assign last_row = (row == RW'(MAP_H - 1));
  // trailing column/row of an odd-sized map has no partner and is dropped
  assign ign      = ((MAP_W % 2 == 1) && last_col) || ((MAP_H % 2 == 1) && last_row);
  assign last_win = (row == RW'(2*HALF_H - 1)) && (col == CW'(2*HALF_W - 1));

  assign v        = data_in[IN_W-1] ? '0 : data_in;
  assign pair_max = (v > hold) ? v : hold;
  assign m        = (lb_rd > pair_max) ? lb_rd : pair_max;

  assign hold_we  = rdata_r && !col[0] && !ign;
  assign lb_we    = rdata_r && !row[0] && col[0] && !ign;
  assign issue    = rdata_r &&  row[0] && col[0] && !ign;

  pool_linebuf #(.W(IN_W), .DEPTH(HALF_W)) u_lb (
    .clk   (clk),
    .we    (lb_we),
    .waddr (AW'(col >> 1)),
    .wdata (pair_max),
    .raddr (AW'(col >> 1)),
    .rdata (lb_rd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      data_out   <= '0;
      wdata_r    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wdata_r    <= issue;
      frame_done <= issue && last_win;
      if (issue)   data_out <= OUT_W'(sat_shift(m, SHIFT, OUT_W));
      if (hold_we) hold     <= v;
      if (rdata_r) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end
endmodule
